// File: rtl/lstm_dout_accum.sv
// Recurrent-error accumulator: collects the four gate deltas, forms
// dy + sum(u_g * d_g) with one serial MAC per gate, and keeps per-gate bias sums.
module lstm_dout_accum #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FRAC  = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [1:0]       i_gate,
  input  logic [WIDTH-1:0] i_dgate,
  input  logic [WIDTH-1:0] dy,
  input  logic [WIDTH-1:0] u_a,
  input  logic [WIDTH-1:0] u_i,
  input  logic [WIDTH-1:0] u_f,
  input  logic [WIDTH-1:0] u_o,
  input  logic             clr_db,
  input  logic             i_ack,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_d_out,
  output logic [WIDTH-1:0] o_db_a,
  output logic [WIDTH-1:0] o_db_i,
  output logic [WIDTH-1:0] o_db_f,
  output logic [WIDTH-1:0] o_db_o
);

  typedef enum logic [1:0] {StCollect, StMac, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] gate_q [4];
  logic [WIDTH-1:0] db_q   [4];
  logic [3:0]       mask_q;
  logic [1:0]       cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] d_out_q;
  logic             valid_q;

  logic                    accept;
  logic [3:0]              gate_bit;
  logic                    set_done;
  logic [WIDTH-1:0]        w_sel;
  logic signed [2*WIDTH-1:0] prod_full;
  logic signed [2*WIDTH-1:0] prod_sh;
  logic [WIDTH-1:0]        prod;
  logic [WIDTH-1:0]        acc_next;

  assign accept   = i_valid && o_ready;
  assign gate_bit = 4'b0001 << i_gate;
  assign set_done = accept && ((mask_q | gate_bit) == 4'hF);

  // Weights are read live each MAC cycle; the driver holds them stable.
  always_comb begin
    w_sel = u_a;
    unique case (cnt_q)
      2'd0: w_sel = u_a;
      2'd1: w_sel = u_i;
      2'd2: w_sel = u_f;
      2'd3: w_sel = u_o;
      default: w_sel = u_a;
    endcase
  end

  assign prod_full = $signed(gate_q[cnt_q]) * $signed(w_sel);
  assign prod_sh   = prod_full >>> FRAC;
  assign prod      = prod_sh[WIDTH-1:0];
  assign acc_next  = acc_q + prod;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= StCollect;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StCollect: if (set_done)      state_d = StMac;
      StMac:     if (cnt_q == 2'd3) state_d = StDone;
      StDone:    if (i_ack)         state_d = StCollect;
      default:                      state_d = StCollect;
    endcase
  end

  // Output decode
  always_comb begin
    o_ready = (state_q == StCollect);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) gate_q[k] <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      d_out_q <= '0;
      valid_q <= 1'b0;
    end else begin
      if (accept) begin
        gate_q[i_gate] <= i_dgate;
        mask_q         <= mask_q | gate_bit;
      end
      if (set_done) begin
        acc_q <= dy;
        cnt_q <= 2'd0;
      end
      if (state_q == StMac) begin
        acc_q <= acc_next;
        cnt_q <= cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          d_out_q <= acc_next;
          valid_q <= 1'b1;
          mask_q  <= '0;
        end
      end
      if (state_q == StDone && i_ack) valid_q <= 1'b0;
    end
  end

  // A clear coinciding with a beat leaves just that beat in its accumulator.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) db_q[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (clr_db) begin
          db_q[k] <= (accept && i_gate == k[1:0]) ? i_dgate : '0;
        end else if (accept && i_gate == k[1:0]) begin
          db_q[k] <= db_q[k] + i_dgate;
        end
      end
    end
  end

  assign o_valid = valid_q;
  assign o_d_out = d_out_q;
  assign o_db_a  = db_q[0];
  assign o_db_i  = db_q[1];
  assign o_db_f  = db_q[2];
  assign o_db_o  = db_q[3];

endmodule

// File: tb/tb_lstm_dout_accum.sv
// Bench for lstm_dout_accum: directed scenarios plus randomized sets checked
// against a plain-arithmetic model of the recurrent error and bias sums.
module tb_lstm_dout_accum;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned FRAC  = 24;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             i_valid = 1'b0;
  logic [1:0]       i_gate = '0;
  logic [WIDTH-1:0] i_dgate = '0;
  logic [WIDTH-1:0] dy = '0;
  logic [WIDTH-1:0] u_a = '0, u_i = '0, u_f = '0, u_o = '0;
  logic             clr_db = 1'b0;
  logic             i_ack = 1'b0;
  logic             o_ready, o_valid;
  logic [WIDTH-1:0] o_d_out, o_db_a, o_db_i, o_db_f, o_db_o;

  lstm_dout_accum #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_gate(i_gate), .i_dgate(i_dgate),
    .dy(dy), .u_a(u_a), .u_i(u_i), .u_f(u_f), .u_o(u_o), .clr_db(clr_db),
    .i_ack(i_ack), .o_ready(o_ready), .o_valid(o_valid), .o_d_out(o_d_out),
    .o_db_a(o_db_a), .o_db_i(o_db_i), .o_db_f(o_db_f), .o_db_o(o_db_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] gm   [4];
  logic [31:0] db_m [4];
  logic [31:0] dbo  [4];

  assign dbo[0] = o_db_a;
  assign dbo[1] = o_db_i;
  assign dbo[2] = o_db_f;
  assign dbo[3] = o_db_o;

  // Reference: dy + sum over gates of (d*u >> FRAC), all wrapping at 32 bits.
  function automatic logic [31:0] model_dout();
    logic [31:0] s;
    logic [31:0] w [4];
    longint p;
    w[0] = u_a; w[1] = u_i; w[2] = u_f; w[3] = u_o;
    s = dy;
    for (int k = 0; k < 4; k++) begin
      p = longint'($signed(gm[k])) * longint'($signed(w[k]));
      p = p >>> FRAC;
      s = s + p[31:0];
    end
    return s;
  endfunction

  task automatic beat(input logic [1:0] g, input logic [31:0] v);
    i_valid = 1'b1; i_gate = g; i_dgate = v;
    @(posedge clk); #1;
    i_valid = 1'b0;
    gm[g] = v;
    if (clr_db) begin
      for (int k = 0; k < 4; k++) db_m[k] = '0;
      db_m[g] = v;
    end else begin
      db_m[g] = db_m[g] + v;
    end
  endtask

  task automatic check_db(input string name);
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (dbo[k] !== db_m[k]) begin
        n_fail++;
        $display("FAIL %s db[%0d]: got %h, expected %h", name, k, dbo[k], db_m[k]);
      end
    end
  endtask

  // Called right after the set-completing beat; expects o_valid 4 edges later.
  task automatic wait_result(input logic [31:0] exp, input string name, input logic do_ack);
    int n = 0;
    while (!o_valid && n < 12) begin
      @(posedge clk); #1; n++;
    end
    n_tests++;
    if (n != 4) begin
      n_fail++;
      $display("FAIL %s latency: got %0d edges, expected 4", name, n);
    end
    n_tests++;
    if (o_d_out !== exp) begin
      n_fail++;
      $display("FAIL %s d_out: got %h, expected %h", name, o_d_out, exp);
    end
    check_db(name);
    if (do_ack) begin
      i_ack = 1'b1; @(posedge clk); #1; i_ack = 1'b0;
      n_tests++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL %s ack: got valid=%b ready=%b, expected valid=0 ready=1",
                 name, o_valid, o_ready);
      end
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 4; k++) begin db_m[k] = '0; gm[k] = '0; end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    clear_model();
    n_tests++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_d_out !== '0) begin
      n_fail++;
      $display("FAIL reset: got valid=%b ready=%b d_out=%h, expected 0 1 0",
               o_valid, o_ready, o_d_out);
    end
    check_db("reset");
  endtask

  task automatic test_basic();
    u_a = 32'h0080_0000; u_i = 32'h0080_0000; u_f = 32'h0080_0000; u_o = 32'h0080_0000;
    dy = '0;
    beat(2'd0, 32'h0100_0000);
    @(posedge clk); #1;
    beat(2'd1, 32'h0100_0000);
    beat(2'd2, 32'h0100_0000);
    beat(2'd3, 32'h0100_0000);
    wait_result(32'h0200_0000, "basic", 1'b1);
  endtask

  task automatic test_signed();
    u_a = 32'h0080_0000; dy = 32'h0040_0000;
    beat(2'd0, 32'hFF00_0000);
    beat(2'd1, 32'h0);
    beat(2'd2, 32'h0);
    beat(2'd3, 32'h0);
    wait_result(32'hFFC0_0000, "signed", 1'b1);
  endtask

  task automatic test_out_of_order();
    rst = 1'b0; @(posedge clk); #1 rst = 1'b1;
    clear_model();
    u_a = 32'h0100_0000; dy = '0;
    beat(2'd3, 32'h0);
    beat(2'd0, 32'h0100_0000);
    beat(2'd0, 32'h0200_0000);
    beat(2'd2, 32'h0);
    beat(2'd1, 32'h0);
    n_tests++;
    if (db_m[0] !== 32'h0300_0000) begin
      n_fail++;
      $display("FAIL ooo model db_a: got %h, expected 03000000", db_m[0]);
    end
    wait_result(32'h0200_0000, "ooo", 1'b1);
  endtask

  task automatic test_backpressure();
    logic [31:0] exp;
    u_a = 32'h0123_4567; u_i = 32'hFF80_0000; u_f = 32'h0020_0000; u_o = 32'h0300_0000;
    dy = 32'h0011_0000;
    beat(2'd1, 32'h0200_0000);
    beat(2'd3, 32'hFFF0_0000);
    beat(2'd0, 32'h0050_0000);
    beat(2'd2, 32'h7000_0000);
    exp = model_dout();
    wait_result(exp, "bp", 1'b0);
    i_valid = 1'b1; i_gate = 2'd2; i_dgate = 32'h0555_0000;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_tests++;
      if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_d_out !== exp) begin
        n_fail++;
        $display("FAIL bp hold cycle %0d: got ready=%b valid=%b d_out=%h, expected 0 1 %h",
                 c, o_ready, o_valid, o_d_out, exp);
      end
    end
    i_valid = 1'b0;
    check_db("bp_hold");
    i_ack = 1'b1; @(posedge clk); #1; i_ack = 1'b0;
    n_tests++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_d_out !== exp) begin
      n_fail++;
      $display("FAIL bp release: got ready=%b valid=%b d_out=%h, expected 1 0 %h",
               o_ready, o_valid, o_d_out, exp);
    end
  endtask

  task automatic test_bias_clear();
    clr_db = 1'b1; @(posedge clk); #1 clr_db = 1'b0;
    for (int k = 0; k < 4; k++) db_m[k] = '0;
    check_db("clr_only");
    for (int s = 0; s < 2; s++) begin
      beat(2'd0, 32'h0); beat(2'd1, 32'h0040_0000); beat(2'd2, 32'h0); beat(2'd3, 32'h0);
      wait_result(model_dout(), "bias_set", 1'b1);
    end
    n_tests++;
    if (o_db_i !== 32'h0080_0000) begin
      n_fail++;
      $display("FAIL bias_i: got %h, expected 00800000", o_db_i);
    end
    clr_db = 1'b1;
    beat(2'd1, 32'h0010_0000);
    clr_db = 1'b0;
    n_tests++;
    if (o_db_i !== 32'h0010_0000 || o_db_a !== '0 || o_db_f !== '0 || o_db_o !== '0) begin
      n_fail++;
      $display("FAIL clr_with_beat: got a=%h i=%h f=%h o=%h, expected 0 00100000 0 0",
               o_db_a, o_db_i, o_db_f, o_db_o);
    end
    beat(2'd0, 32'h0100_0000); beat(2'd2, 32'h0); beat(2'd3, 32'h0);
    wait_result(model_dout(), "clr_set", 1'b1);
  endtask

  task automatic test_reset_mid_mac();
    beat(2'd0, 32'h0100_0000); beat(2'd1, 32'h0200_0000);
    beat(2'd2, 32'h0300_0000); beat(2'd3, 32'h0400_0000);
    rst = 1'b0; @(posedge clk); #1 rst = 1'b1;
    clear_model();
    n_tests++;
    if (o_valid !== 1'b0 || o_d_out !== '0 || o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_mac reset: got valid=%b d_out=%h ready=%b, expected 0 0 1",
               o_valid, o_d_out, o_ready);
    end
    check_db("mid_mac_reset");
    u_a = 32'h0100_0000; u_i = 32'h0080_0000; u_f = 32'hFF00_0000; u_o = 32'h0040_0000;
    dy = 32'h0001_0000;
    beat(2'd2, 32'h0100_0000); beat(2'd0, 32'h0020_0000);
    beat(2'd3, 32'h0400_0000); beat(2'd1, 32'hFE00_0000);
    wait_result(model_dout(), "after_reset", 1'b1);
  endtask

  task automatic test_random();
    logic [1:0] ord [4];
    logic [1:0] t;
    int j;
    for (int it = 0; it < 20; it++) begin
      for (int k = 0; k < 4; k++) ord[k] = 2'(k);
      for (int k = 3; k > 0; k--) begin
        j = $urandom_range(0, k);
        t = ord[k]; ord[k] = ord[j]; ord[j] = t;
      end
      u_a = $urandom; u_i = $urandom; u_f = $urandom; u_o = $urandom; dy = $urandom;
      for (int p = 0; p < 4; p++) begin
        if (p > 0 && $urandom_range(0, 3) == 0) beat(ord[$urandom_range(0, p - 1)], $urandom);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        beat(ord[p], $urandom);
      end
      wait_result(model_dout(), "random", 1'b1);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_signed();
    test_out_of_order();
    test_backpressure();
    test_bias_clear();
    test_reset_mid_mac();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
